// File: rtl/sipo_deser.sv
// Multi-lane serial-to-parallel deserializer with selectable bit order.
// Completed words go to a holding register with a valid/ready handshake and sticky overflow detection.
module sipo_deser #(
  parameter  int COLS  = 16,
  parameter  int LANES = 1,
  localparam int BEATS = COLS / LANES,
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             clr,
  input  logic             msb_first,
  input  logic             sin_valid,
  input  logic [LANES-1:0] sin,
  output logic             word_valid,
  input  logic             word_ready,
  output logic [COLS-1:0]  word_out,
  output logic [CW-1:0]    beat_cnt,
  output logic             overflow
);

  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  generate
    if ((LANES < 1) || (LANES > COLS) || ((COLS % LANES) != 0)) begin : g_bad_params
      $error("sipo_deser: COLS must be a non-zero multiple of LANES");
    end
  endgenerate

  logic [COLS-1:0] sr_reg;
  logic [COLS-1:0] sr_next;
  logic [COLS-1:0] word_reg;
  logic [CW-1:0]   beat_cnt_reg;
  logic            word_valid_reg;
  logic            overflow_reg;
  logic            mode_reg;

  logic [COLS-1:0] shift_msb;
  logic [COLS-1:0] shift_lsb;
  logic            mode_eff;
  logic            last_beat;
  logic            complete;
  logic            hold_free;

  generate
    if (BEATS == 1) begin : g_single_beat
      assign shift_msb = sin;
      assign shift_lsb = sin;
    end else begin : g_multi_beat
      assign shift_msb = {sr_reg[COLS-LANES-1:0], sin};
      assign shift_lsb = {sin, sr_reg[COLS-1:LANES]};
    end
  endgenerate

  // The first beat of a word already obeys the msb_first value it latches.
  assign mode_eff  = (beat_cnt_reg == '0) ? msb_first : mode_reg;
  assign sr_next   = mode_eff ? shift_msb : shift_lsb;
  assign last_beat = (beat_cnt_reg == LAST_BEAT);
  assign complete  = sin_valid && last_beat;
  assign hold_free = !word_valid_reg || word_ready;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sr_reg         <= '0;
      word_reg       <= '0;
      beat_cnt_reg   <= '0;
      word_valid_reg <= 1'b0;
      overflow_reg   <= 1'b0;
      mode_reg       <= 1'b1;
    end else if (clr) begin
      sr_reg         <= '0;
      beat_cnt_reg   <= '0;
      word_valid_reg <= 1'b0;
      overflow_reg   <= 1'b0;
    end else begin
      if (sin_valid) begin
        sr_reg       <= sr_next;
        beat_cnt_reg <= last_beat ? '0 : beat_cnt_reg + 1'b1;
        if (beat_cnt_reg == '0) begin
          mode_reg <= msb_first;
        end
      end
      // A completing word either refills the holding register (possibly on the
      // same edge the old word is accepted) or is dropped and flagged.
      if (complete) begin
        if (hold_free) begin
          word_reg       <= sr_next;
          word_valid_reg <= 1'b1;
        end else begin
          overflow_reg <= 1'b1;
        end
      end else if (word_valid_reg && word_ready) begin
        word_valid_reg <= 1'b0;
      end
    end
  end

  assign word_valid = word_valid_reg;
  assign word_out   = word_reg;
  assign beat_cnt   = beat_cnt_reg;
  assign overflow   = overflow_reg;

endmodule
